// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//   Sequencing controller for a 16-line, direct-mapped, one-word-per-line data
//   cache. Write-through, no-write-allocate. Owns the valid/tag/data arrays and
//   the FSM that handles load hits, miss fills, write-through stores and
//   single-line / whole-cache flushes.
//
//   Address split: tag = addr[31:6], index = addr[5:2], addr[1:0] ignored.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   iReq/iWrite/iAddress/iWriteData   CPU request (accepted only when oReady)
//   oReady            FSM is in IDLE
//   oRespValid        one-cycle completion pulse, oReadData valid for loads
//   oReadData         load data
//   iFlushReq/iFlushAll/iFlushAddress flush request (wins over iReq)
//   oFlushDone        one-cycle flush completion pulse
//   oMemReq/oMemWrite/oMemAddress/oMemWriteData  main-memory request
//   iMemAck/iMemReadData              main-memory completion
//   oHitCount/oMissCount              saturating load hit/miss counters
// -----------------------------------------------------------------------------
module dcache_controller #(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iReq,
  input  logic             iWrite,
  input  logic [31:0]      iAddress,
  input  logic [31:0]      iWriteData,
  output logic             oReady,
  output logic             oRespValid,
  output logic [31:0]      oReadData,
  input  logic             iFlushReq,
  input  logic             iFlushAll,
  input  logic [31:0]      iFlushAddress,
  output logic             oFlushDone,
  output logic             oMemReq,
  output logic             oMemWrite,
  output logic [31:0]      oMemAddress,
  output logic [31:0]      oMemWriteData,
  input  logic             iMemAck,
  input  logic [31:0]      iMemReadData,
  output logic [CNT_W-1:0] oHitCount,
  output logic [CNT_W-1:0] oMissCount
);

  localparam int IDX_W = 4;
  localparam int TAG_W = 26;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[5:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:6];
  endfunction

  state_t state_r;
  state_t state_next_s;

  // Latched request
  logic        req_write_r;
  logic [31:0] req_addr_r;
  logic [31:0] req_wdata_r;

  // Cache arrays
  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  logic [IDX_W-1:0] flush_cnt_r;

  // Registered outputs
  logic             resp_valid_r;
  logic [31:0]      read_data_r;
  logic             flush_done_r;
  logic             mem_req_r;
  logic             mem_write_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  // Per-cycle events decoded by the FSM
  logic             accept_s;
  logic             flush_line_s;
  logic             flush_all_s;
  logic             load_hit_s;
  logic             load_miss_s;
  logic             store_start_s;
  logic             store_hit_s;
  logic             fill_done_s;
  logic             write_done_s;
  logic             flush_step_s;
  logic             flush_last_s;

  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic             lookup_hit_s;
  logic             unused_bits_s;

  assign req_idx_s    = addr_index(req_addr_r);
  assign req_tag_s    = addr_tag(req_addr_r);
  assign lookup_hit_s = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

  // Byte-offset bits and the flush tag never influence the cache.
  assign unused_bits_s = ^{req_addr_r[1:0], iFlushAddress[31:6], iFlushAddress[1:0]};

  assign oReady        = (state_r == ST_IDLE);
  assign oRespValid    = resp_valid_r;
  assign oReadData     = read_data_r;
  assign oFlushDone    = flush_done_r;
  assign oMemReq       = mem_req_r;
  assign oMemWrite     = mem_write_r;
  assign oMemAddress   = mem_addr_r;
  assign oMemWriteData = mem_wdata_r;
  assign oHitCount     = hit_cnt_r;
  assign oMissCount    = miss_cnt_r;

  // Next-state decode and per-cycle event flags
  always_comb begin
    state_next_s  = state_r;
    accept_s      = 1'b0;
    flush_line_s  = 1'b0;
    flush_all_s   = 1'b0;
    load_hit_s    = 1'b0;
    load_miss_s   = 1'b0;
    store_start_s = 1'b0;
    store_hit_s   = 1'b0;
    fill_done_s   = 1'b0;
    write_done_s  = 1'b0;
    flush_step_s  = 1'b0;
    flush_last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A flush takes priority; a simultaneous iReq stays pending at the requester.
        if (iFlushReq) begin
          if (iFlushAll) begin
            flush_all_s  = 1'b1;
            state_next_s = ST_FLUSH;
          end else begin
            flush_line_s = 1'b1;
            state_next_s = ST_IDLE;
          end
        end else if (iReq) begin
          accept_s     = 1'b1;
          state_next_s = ST_LOOKUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (req_write_r) begin
          store_start_s = 1'b1;
          store_hit_s   = lookup_hit_s;
          state_next_s  = ST_WRITE;
        end else if (lookup_hit_s) begin
          load_hit_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          load_miss_s  = 1'b1;
          state_next_s = ST_FILL;
        end
      end
      ST_FILL: begin
        if (iMemAck) begin
          fill_done_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (iMemAck) begin
          write_done_s = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_FLUSH: begin
        flush_step_s = 1'b1;
        if (flush_cnt_r == 4'd15) begin
          flush_last_s = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, captured on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      req_write_r <= 1'b0;
      req_addr_r  <= 32'd0;
      req_wdata_r <= 32'd0;
    end else if (accept_s) begin
      req_write_r <= iWrite;
      req_addr_r  <= iAddress;
      req_wdata_r <= iWriteData;
    end
  end

  // Valid bits: cleared by reset or flush, set by a completed fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (flush_line_s) begin
      valid_r[addr_index(iFlushAddress)] <= 1'b0;
    end else if (flush_step_s) begin
      valid_r[flush_cnt_r] <= 1'b0;
    end else if (fill_done_s) begin
      valid_r[req_idx_s] <= 1'b1;
    end
  end

  // Tag/data arrays; contents are meaningless while the valid bit is clear
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_r[req_idx_s]  <= req_tag_s;
      data_r[req_idx_s] <= iMemReadData;
    end else if (store_hit_s) begin
      data_r[req_idx_s] <= req_wdata_r;
    end
  end

  // Flush-all line walker
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_r <= 4'd0;
    end else if (flush_all_s) begin
      flush_cnt_r <= 4'd0;
    end else if (flush_step_s) begin
      flush_cnt_r <= flush_cnt_r + 4'd1;
    end
  end

  // Response and flush-done pulses plus load data
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      flush_done_r <= 1'b0;
      read_data_r  <= 32'd0;
    end else begin
      resp_valid_r <= load_hit_s | fill_done_s | write_done_s;
      flush_done_r <= flush_line_s | flush_last_s;
      if (load_hit_s) begin
        read_data_r <= data_r[req_idx_s];
      end else if (fill_done_s) begin
        read_data_r <= iMemReadData;
      end
    end
  end

  // Main-memory request: raised on entry to FILL/WRITE, dropped after the ack
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else if (load_miss_s) begin
      mem_req_r   <= 1'b1;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {req_addr_r[31:2], 2'b00};
    end else if (store_start_s) begin
      mem_req_r   <= 1'b1;
      mem_write_r <= 1'b1;
      mem_addr_r  <= {req_addr_r[31:2], 2'b00};
      mem_wdata_r <= req_wdata_r;
    end else if (fill_done_s || write_done_s) begin
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
    end
  end

  // Saturating load hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (load_hit_s && (hit_cnt_r != CNT_MAX)) begin
        hit_cnt_r <= hit_cnt_r + CNT_ONE;
      end
      if (load_miss_s && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, iWrite;
  logic [31:0] iAddress, iWriteData;
  logic        oReady, oRespValid;
  logic [31:0] oReadData;
  logic        iFlushReq, iFlushAll;
  logic [31:0] iFlushAddress;
  logic        oFlushDone;
  logic        oMemReq, oMemWrite;
  logic [31:0] oMemAddress, oMemWriteData;
  logic        iMemAck;
  logic [31:0] iMemReadData;
  logic [15:0] oHitCount, oMissCount;

  logic        model_ack = 1'b0;
  logic [31:0] model_rdata = 32'd0;
  logic        stray_ack;
  logic [31:0] stray_data;

  assign iMemAck      = model_ack | stray_ack;
  assign iMemReadData = stray_ack ? stray_data : model_rdata;

  int checks = 0;
  int failures = 0;
  int flush_seen = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } mem_t;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
  } resp_t;

  mem_t  mem_q[$];
  resp_t resp_q[$];

  dcache_controller #(.LINES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iWrite(iWrite), .iAddress(iAddress), .iWriteData(iWriteData),
    .oReady(oReady), .oRespValid(oRespValid), .oReadData(oReadData),
    .iFlushReq(iFlushReq), .iFlushAll(iFlushAll), .iFlushAddress(iFlushAddress),
    .oFlushDone(oFlushDone),
    .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddress(oMemAddress),
    .oMemWriteData(oMemWriteData), .iMemAck(iMemAck), .iMemReadData(iMemReadData),
    .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int delay);
    mem_t m;
    m.wr = wr; m.addr = addr; m.wdata = wd; m.rdata = rd; m.delay = delay;
    mem_q.push_back(m);
  endtask

  task automatic exp_resp(input logic is_load, input logic [31:0] data);
    resp_t r;
    r.is_load = is_load; r.data = data;
    resp_q.push_back(r);
  endtask

  // Main-memory model: checks each request against mem_q, acks after its delay.
  int   req_cnt = 0;
  mem_t cur;
  always @(negedge clk) begin
    if (model_ack) begin
      model_ack = 1'b0;
      chk("mem_req_drop", 32'(oMemReq), 32'd0);
      req_cnt = 0;
    end else if (oMemReq) begin
      if (req_cnt == 0) begin
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected actual=0x%08h expected=none", oMemAddress);
          cur.wr = 1'b0; cur.addr = oMemAddress; cur.wdata = 32'd0; cur.rdata = 32'd0; cur.delay = 1;
        end else begin
          cur = mem_q.pop_front();
          chk("mem_write", 32'(oMemWrite), 32'(cur.wr));
          chk("mem_addr", oMemAddress, cur.addr);
          if (cur.wr) chk("mem_wdata", oMemWriteData, cur.wdata);
        end
      end else begin
        chk("mem_addr_hold", oMemAddress, cur.addr);
      end
      req_cnt++;
      if (req_cnt == cur.delay) begin
        model_ack   = 1'b1;
        model_rdata = cur.rdata;
      end
    end else begin
      req_cnt = 0;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT completes an access.
  resp_t got;
  always @(negedge clk) begin
    if (oRespValid) begin
      if (resp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_unexpected actual=0x%08h expected=none", oReadData);
      end else begin
        got = resp_q.pop_front();
        if (got.is_load) chk("resp_data", oReadData, got.data);
      end
    end
    if (oFlushDone) flush_seen++;
  end

  // Issue one access (called at a negedge); checks latency from acceptance.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input string name);
    int guard;
    int lat;
    iReq = 1'b1; iWrite = wr; iAddress = addr; iWriteData = wd;
    guard = 0;
    while (!oReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    iReq = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!oRespValid && lat < 200);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic hit,
                      input int delay, input string name);
    if (!hit) exp_mem(1'b0, {addr[31:2], 2'b00}, 32'd0, data, delay);
    exp_resp(1'b1, data);
    access(1'b0, addr, 32'd0, hit ? 2 : 2 + delay, name);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input int delay,
                       input string name);
    exp_mem(1'b1, {addr[31:2], 2'b00}, data, 32'd0, delay);
    exp_resp(1'b0, 32'd0);
    access(1'b1, addr, data, 2 + delay, name);
  endtask

  task automatic counts(input logic [15:0] hits, input logic [15:0] misses, input string name);
    chk({name, "_hits"}, 32'(oHitCount), 32'(hits));
    chk({name, "_misses"}, 32'(oMissCount), 32'(misses));
  endtask

  task automatic flush_line(input logic [31:0] addr);
    iFlushReq = 1'b1; iFlushAll = 1'b0; iFlushAddress = addr;
    @(posedge clk); #1;
    iFlushReq = 1'b0;
    @(negedge clk);
    chk("flush_line_done", 32'(oFlushDone), 32'd1);
  endtask

  task automatic flush_all();
    int n;
    iFlushReq = 1'b1; iFlushAll = 1'b1;
    @(posedge clk); #1;
    iFlushReq = 1'b0; iFlushAll = 1'b0;
    n = 0;
    @(negedge clk);
    while (!oReady && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("flush_all_busy", 32'(n), 32'd16);
    chk("flush_all_done", 32'(oFlushDone), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; iReq = 1'b0; iWrite = 1'b0; iAddress = 32'd0; iWriteData = 32'd0;
    iFlushReq = 1'b0; iFlushAll = 1'b0; iFlushAddress = 32'd0;
    stray_ack = 1'b0; stray_data = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_resp", 32'(oRespValid), 32'd0);
    chk("rst_fdone", 32'(oFlushDone), 32'd0);
    chk("rst_memreq", 32'(oMemReq), 32'd0);
    chk("rst_memwr", 32'(oMemWrite), 32'd0);
    chk("rst_rdata", oReadData, 32'd0);
    chk("rst_maddr", oMemAddress, 32'd0);
    chk("rst_mwdata", oMemWriteData, 32'd0);
    counts(16'd0, 16'd0, "rst");

    // Miss fill, then hit
    load(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 3, "miss40");
    counts(16'd0, 16'd1, "miss40");
    load(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 0, "hit40");
    counts(16'd1, 16'd1, "hit40");

    // Conflict on index 0
    load(32'h0000_0080, 32'h0BAD_F00D, 1'b0, 1, "miss80");
    load(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 2, "remiss40");
    counts(16'd1, 16'd3, "conflict");

    // Store hit updates the line and writes through
    store(32'h0000_0040, 32'h1234_5678, 2, "st40");
    load(32'h0000_0040, 32'h1234_5678, 1'b1, 0, "hitst40");
    load(32'h0000_0043, 32'h1234_5678, 1'b1, 0, "hit43");
    counts(16'd3, 16'd3, "store");

    // Store miss does not allocate; offset bits ignored
    store(32'h0000_0C44, 32'hCAFE_0001, 1, "stC44");
    load(32'h0000_0C44, 32'h5555_AAAA, 1'b0, 1, "missC44");
    load(32'h0000_0C47, 32'h5555_AAAA, 1'b1, 0, "hitC47");
    store(32'h0000_0C46, 32'h7777_0000, 1, "stC46");
    load(32'h0000_0C44, 32'h7777_0000, 1'b1, 0, "hitC44");
    counts(16'd5, 16'd4, "nowa");

    // Single-line flush
    flush_line(32'h0000_0043);
    load(32'h0000_0040, 32'h1234_5678, 1'b0, 1, "fl_miss40");
    load(32'h0000_0C44, 32'h7777_0000, 1'b1, 0, "fl_hitC44");

    // Flush all
    flush_all();
    load(32'h0000_0040, 32'h1234_5678, 1'b0, 1, "fa_miss40");
    load(32'h0000_0C44, 32'h7777_0000, 1'b0, 1, "fa_missC44");
    counts(16'd6, 16'd7, "flushall");

    // Flush and request in the same cycle: flush first
    iReq = 1'b1; iWrite = 1'b0; iAddress = 32'h0000_0C44;
    iFlushReq = 1'b1; iFlushAll = 1'b0; iFlushAddress = 32'h0000_0C44;
    @(posedge clk); #1;
    iFlushReq = 1'b0;
    @(negedge clk);
    chk("conc_fdone", 32'(oFlushDone), 32'd1);
    chk("conc_ready", 32'(oReady), 32'd1);
    load(32'h0000_0C44, 32'h7777_0000, 1'b0, 2, "conc_missC44");
    counts(16'd6, 16'd8, "conc");

    // Reset during FILL
    exp_mem(1'b0, 32'h0000_0080, 32'd0, 32'd0, 0);
    iReq = 1'b1; iWrite = 1'b0; iAddress = 32'h0000_0080;
    @(posedge clk); #1;
    iReq = 1'b0;
    repeat (3) @(negedge clk);
    chk("fill_memreq", 32'(oMemReq), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_memreq", 32'(oMemReq), 32'd0);
    chk("abort_ready", 32'(oReady), 32'd1);
    counts(16'd0, 16'd0, "abort");
    load(32'h0000_0040, 32'h1234_5678, 1'b0, 1, "abort_miss40");

    // Stray ack in IDLE is ignored
    stray_data = 32'hFFFF_FFFF;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_resp", 32'(oRespValid), 32'd0);
    chk("stray_ready", 32'(oReady), 32'd1);
    load(32'h0000_0040, 32'h1234_5678, 1'b1, 0, "stray_hit40");
    counts(16'd1, 16'd1, "stray");

    // Hit counter saturation
    force dut.hit_cnt_r = 16'hFFFF;
    #1;
    release dut.hit_cnt_r;
    @(negedge clk);
    chk("sat_pre", 32'(oHitCount), 32'h0000_FFFF);
    load(32'h0000_0040, 32'h1234_5678, 1'b1, 0, "sat_hit40");
    counts(16'hFFFF, 16'd1, "sat");

    repeat (3) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    chk("flush_pulses", 32'(flush_seen), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing controller for the 16-line, direct-mapped, one-word-per-line data cache.
- Address split: tag = address[31:6], index = address[5:2], offset bits [1:0] ignored. The same split applies to the flush address.
- Owns the valid/tag/data arrays and the FSM for hit, miss fill, write-through and flush. Sits between the memory stage and the main-memory port.
- Write-through, no-write-allocate.

Parameters:
- LINES, 16, number of cache lines (index width = 4); fixed by the address split.
- CNT_W, 16, width of the saturating hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- iReq  in  1  CPU access request.
- iWrite  in  1  1 = store, 0 = load; sampled with iReq.
- iAddress  in  32  CPU byte address.
- iWriteData  in  32  store data.
- oReady  out  1  controller is in IDLE and can accept a request this cycle.
- oRespValid  out  1  one-cycle pulse: access complete; oReadData valid for loads.
- oReadData  out  32  load data.
- iFlushReq  in  1  flush request.
- iFlushAll  in  1  1 = invalidate all lines, 0 = invalidate the line at iFlushAddress.
- iFlushAddress  in  32  address of the line to invalidate.
- oFlushDone  out  1  one-cycle pulse when the flush completes.
- oMemReq  out  1  main-memory request; held until acknowledged.
- oMemWrite  out  1  1 = memory write.
- oMemAddress  out  32  word-aligned address ({iAddress[31:2], 2'b00}).
- oMemWriteData  out  32  memory write data.
- iMemAck  in  1  memory has completed the request; iMemReadData is valid in the same cycle.
- iMemReadData  in  32  memory read data.
- oHitCount  out  CNT_W  number of load hits, saturating.
- oMissCount  out  CNT_W  number of load misses, saturating.

Behaviour:
- Reset (rst = 1 at an edge):
  - FSM goes to IDLE and all 16 valid bits clear in that single cycle.
  - oRespValid, oFlushDone, oMemReq, oMemWrite = 0; oReadData, oMemAddress, oMemWriteData = 0; both counters = 0.
  - Reset aborts any state, including a pending memory request; oMemReq is low in the cycle after the reset edge.
- States: IDLE, LOOKUP, FILL, WRITE, FLUSH.
- IDLE (oReady = 1):
  - If iFlushReq = 1, the flush is accepted. A flush wins over an iReq in the same cycle; that iReq is not accepted and must be held by the requester.
  - Otherwise, if iReq = 1, latch iWrite, iAddress and iWriteData, then go to LOOKUP.
  - Single-line flush: clear valid[iFlushAddress[5:2]] at the edge and pulse oFlushDone next cycle; stay in IDLE.
  - Flush all: go to FLUSH.
- LOOKUP (1 cycle): hit = valid[idx] && tag[idx] == latched tag.
  - Load hit: oReadData = data[idx], oRespValid = 1 next cycle, hit count +1, return to IDLE. Load-hit latency = 2 cycles from acceptance to oRespValid.
  - Load miss: miss count +1, go to FILL.
  - Store, hit or miss: go to WRITE. On a store hit, data[idx] is updated in this cycle. A store miss leaves the cache unchanged.
- FILL:
  - oMemReq = 1, oMemWrite = 0; oMemAddress is held stable until iMemAck.
  - On iMemAck: write data[idx] = iMemReadData, tag[idx] = latched tag, valid[idx] = 1; drive oReadData = iMemReadData with oRespValid next cycle; go to IDLE.
- WRITE:
  - oMemReq = 1, oMemWrite = 1; oMemWriteData = latched data.
  - On iMemAck: oRespValid next cycle, go to IDLE.
- iMemAck handling:
  - An ack in the first cycle of oMemReq is legal.
  - iMemAck is ignored outside FILL and WRITE.
  - oMemReq deasserts in the cycle after the ack.
- FLUSH:
  - A 4-bit counter runs 0 to 15 and clears valid[counter] each cycle (16 cycles).
  - After index 15, pulse oFlushDone and return to IDLE.
  - CPU requests are not accepted during FLUSH (oReady = 0).
- Counters saturate at 2^CNT_W - 1 and do not wrap. Stores do not count.
- Offset bits [1:0] never affect hit or miss; 0x104 and 0x107 hit the same line.

Test Plan:
- After reset, load 0x0000_0040 (index 0, tag 1), memory returns 0xDEAD_BEEF with a 3-cycle ack delay -> oMemReq high 3 cycles at 0x40; oRespValid with 0xDEAD_BEEF; missCount = 1. Repeat the load -> hit, oRespValid 2 cycles after acceptance, hitCount = 1, no oMemReq.
- Conflict: load 0x0000_0080 (same index 0, tag 2) after the previous line -> miss, refill. Reload 0x40 -> miss again; missCount = 3.
- Store 0x1234_5678 to 0x40 while resident -> memory write at 0x40 with that data. Following load of 0x40 -> hit returning 0x1234_5678. Store to non-resident 0x0000_0C44 -> memory write only; a load of 0xC44 then misses.
- iFlushReq with iFlushAll = 0 at 0x43 -> valid[0] clears, oFlushDone 1 cycle later, load 0x40 misses. iFlushAll = 1 -> oReady low 16 cycles, oFlushDone pulse, every line misses. iFlushReq and iReq in the same IDLE cycle -> flush first; the request is accepted afterwards.
- Assert rst during FILL with oMemReq high -> oMemReq low next cycle, all counters 0, previously valid lines miss. Drive iMemAck in IDLE -> no effect.
- Force the hit counter to 0xFFFF (CNT_W = 16) and perform one more load hit -> counter stays at 0xFFFF.
